// File: rtl/data_mem_dp.sv
// data_mem_dp: parametrised data RAM with one synchronous write port and two
// independent read ports (A: load/store path, B: debug/dump path).
//
// A synchronous active-high reset starts a clear sweep. The sweep writes one word
// per cycle: zero everywhere, except the two preset addresses. While the sweep
// runs, busy is high, user writes are dropped and flagged on wr_err, and both
// read ports drive 0.
//
// Ports:
//   CLK              clock, rising edge
//   reset            synchronous, active-high; starts/restarts the clear sweep
//   WrAddr/WriteMem/DataIn        write port
//   RdAddrA/ReadMemA -> DataOutA  read port A
//   RdAddrB/ReadMemB -> DataOutB  read port B
//   busy             high while the clear sweep runs
//   wr_err           one-cycle pulse after a write attempted during the sweep
//
// READ_LAT = 0 gives a combinational read that returns the pre-write value on a
// same-cycle collision. READ_LAT = 1 gives a registered read with write-through.
module data_mem_dp #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 8,
  parameter int unsigned READ_LAT  = 0,
  parameter int unsigned PRE_ADDR0 = 16,
  parameter int unsigned PRE_VAL0  = 254,
  parameter int unsigned PRE_ADDR1 = 244,
  parameter int unsigned PRE_VAL1  = 5
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] WrAddr,
  input  logic          WriteMem,
  input  logic [DW-1:0] DataIn,
  input  logic [AW-1:0] RdAddrA,
  input  logic          ReadMemA,
  output logic [DW-1:0] DataOutA,
  input  logic [AW-1:0] RdAddrB,
  input  logic          ReadMemB,
  output logic [DW-1:0] DataOutB,
  output logic          busy,
  output logic          wr_err
);

  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_err_q, wr_err_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] preset_val;

  // Compared at 32 bits so a preset address beyond DEPTH never aliases onto a
  // low address. The second preset is checked last so it wins on a collision.
  always_comb begin
    preset_val = '0;
    if (32'(cnt_q) == PRE_ADDR0) preset_val = DW'(PRE_VAL0);
    if (32'(cnt_q) == PRE_ADDR1) preset_val = DW'(PRE_VAL1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_err_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = WrAddr;
    mem_wdata = DataIn;
    if (reset) begin
      state_d = StClear;
      cnt_d   = '0;
    end else if (state_q == StClear) begin
      // The sweep owns the write port; user writes are dropped and flagged.
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = preset_val;
      cnt_d     = cnt_q + 1'b1;
      wr_err_d  = WriteMem;
      if (cnt_q == {AW{1'b1}}) state_d = StReady;
    end else begin
      mem_we = WriteMem;
    end
  end

  always_ff @(posedge CLK) begin
    state_q  <= state_d;
    cnt_q    <= cnt_d;
    wr_err_q <= wr_err_d;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign busy   = (state_q == StClear);
  assign wr_err = wr_err_q;

  // Both read ports are built from one template.
  logic [AW-1:0] rd_addr [2];
  logic          rd_req  [2];
  logic [DW-1:0] rd_data [2];

  assign rd_addr[0] = RdAddrA;
  assign rd_addr[1] = RdAddrB;
  assign rd_req[0]  = ReadMemA;
  assign rd_req[1]  = ReadMemB;
  assign DataOutA   = rd_data[0];
  assign DataOutB   = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic rd_en;
    assign rd_en = rd_req[p] && (state_q == StReady);

    if (READ_LAT == 0) begin : g_comb
      assign rd_data[p] = rd_en ? mem_q[rd_addr[p]] : '0;
    end else begin : g_reg
      logic [DW-1:0] data_q, data_d;

      // Write-through makes a same-cycle write visible in the registered read.
      always_comb begin
        data_d = '0;
        if (rd_en) begin
          data_d = (WriteMem && (WrAddr == rd_addr[p])) ? DataIn : mem_q[rd_addr[p]];
        end
      end

      always_ff @(posedge CLK) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
      end

      assign rd_data[p] = data_q;
    end
  end

endmodule

// File: tb/tb_data_mem_dp.sv
module tb_data_mem_dp;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset;
  logic [7:0] wr_addr, data_in, rd_addr_a, rd_addr_b;
  logic       write_mem, read_a, read_b;
  logic [7:0] d0_a, d0_b, d1_a, d1_b;
  logic       d0_busy, d0_err, d1_busy, d1_err;

  logic [3:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b;
  logic [15:0] s_data_in, s_a, s_b;
  logic        s_write, s_read_a, s_read_b, s_busy, s_err;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [7:0] ref_mem [256];

  data_mem_dp #(.READ_LAT(0)) u_d0 (
    .CLK(CLK), .reset(reset), .WrAddr(wr_addr), .WriteMem(write_mem), .DataIn(data_in),
    .RdAddrA(rd_addr_a), .ReadMemA(read_a), .DataOutA(d0_a),
    .RdAddrB(rd_addr_b), .ReadMemB(read_b), .DataOutB(d0_b),
    .busy(d0_busy), .wr_err(d0_err)
  );

  data_mem_dp #(.READ_LAT(1)) u_d1 (
    .CLK(CLK), .reset(reset), .WrAddr(wr_addr), .WriteMem(write_mem), .DataIn(data_in),
    .RdAddrA(rd_addr_a), .ReadMemA(read_a), .DataOutA(d1_a),
    .RdAddrB(rd_addr_b), .ReadMemB(read_b), .DataOutB(d1_b),
    .busy(d1_busy), .wr_err(d1_err)
  );

  data_mem_dp #(.DW(16), .AW(4), .READ_LAT(0)) u_small (
    .CLK(CLK), .reset(reset), .WrAddr(s_wr_addr), .WriteMem(s_write), .DataIn(s_data_in),
    .RdAddrA(s_rd_addr_a), .ReadMemA(s_read_a), .DataOutA(s_a),
    .RdAddrB(s_rd_addr_b), .ReadMemB(s_read_b), .DataOutB(s_b),
    .busy(s_busy), .wr_err(s_err)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Expected contents right after a complete sweep with default presets.
  task automatic model_sweep;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[16]  = 8'd254;
    ref_mem[244] = 8'd5;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    read_a = 1'b1; read_b = 1'b1;
    rd_addr_a = 8'd16; rd_addr_b = 8'd244;
    tick; tick;
    total++;
    if ({d0_busy, d1_busy, s_busy} !== 3'b111)
      $display("FAIL reset_busy got %b required 111", {d0_busy, d1_busy, s_busy});
    else passed++;
    total++;
    if ({d0_err, d1_err, s_err} !== 3'b000)
      $display("FAIL reset_wr_err got %b required 000", {d0_err, d1_err, s_err});
    else passed++;
    total++;
    if ({d0_a, d0_b, d1_a, d1_b} !== 32'h0)
      $display("FAIL reset_dataout got %h required 0", {d0_a, d0_b, d1_a, d1_b});
    else passed++;
  endtask

  // Releases reset and counts edges until busy falls on each instance.
  task automatic test_sweep(input bit poke);
    int f0 = 0, f1 = 0, fs = 0;
    reset = 1'b0;
    for (int k = 1; k <= 300 && (f0 == 0 || f1 == 0 || fs == 0); k++) begin
      write_mem = poke && (k == 11);
      wr_addr   = 8'd3;
      data_in   = 8'd77;
      read_a    = 1'b1;
      rd_addr_a = k[7:0];
      tick;
      if (d0_busy === 1'b0 && f0 == 0) f0 = k;
      if (d1_busy === 1'b0 && f1 == 0) f1 = k;
      if (s_busy === 1'b0 && fs == 0) fs = k;
      if (poke && (k == 11 || k == 12)) begin
        total++;
        if ({d0_err, d1_err} !== {2{k == 11}})
          $display("FAIL sweep_wr_err edge %0d got %b required %b", k, {d0_err, d1_err},
                   {2{k == 11}});
        else passed++;
      end
      if (k == 50) begin
        total++;
        if ({d0_a, d1_a} !== 16'h0)
          $display("FAIL busy_read_zero got %h required 0", {d0_a, d1_a});
        else passed++;
      end
    end
    write_mem = 1'b0;
    total++;
    if (f0 != 256 || f1 != 256)
      $display("FAIL sweep_len got %0d/%0d required 256", f0, f1);
    else passed++;
    total++;
    if (fs != 16) $display("FAIL small_sweep_len got %0d required 16", fs);
    else passed++;
    model_sweep;
  endtask

  task automatic test_presets;
    int addrs [5] = '{16, 244, 0, 255, 3};
    read_b = 1'b0;
    foreach (addrs[i]) begin
      read_a    = 1'b1;
      rd_addr_a = addrs[i][7:0];
      #1;
      total++;
      if (d0_a !== ref_mem[addrs[i]])
        $display("FAIL preset_lat0 M[%0d] got %0d required %0d", addrs[i], d0_a,
                 ref_mem[addrs[i]]);
      else passed++;
      tick;
      total++;
      if (d1_a !== ref_mem[addrs[i]])
        $display("FAIL preset_lat1 M[%0d] got %0d required %0d", addrs[i], d1_a,
                 ref_mem[addrs[i]]);
      else passed++;
    end
  endtask

  task automatic test_dual_read;
    read_a = 1'b0; read_b = 1'b0;
    write_mem = 1'b1; wr_addr = 8'd40; data_in = 8'hA5; tick;
    wr_addr = 8'd41; data_in = 8'h3C; tick;
    write_mem = 1'b0;
    ref_mem[40] = 8'hA5; ref_mem[41] = 8'h3C;
    read_a = 1'b1; rd_addr_a = 8'd40;
    read_b = 1'b1; rd_addr_b = 8'd41;
    #1;
    total++;
    if ({d0_a, d0_b} !== {ref_mem[40], ref_mem[41]})
      $display("FAIL dual_lat0 got %h required %h", {d0_a, d0_b}, {ref_mem[40], ref_mem[41]});
    else passed++;
    tick;
    total++;
    if ({d1_a, d1_b} !== {ref_mem[40], ref_mem[41]})
      $display("FAIL dual_lat1 got %h required %h", {d1_a, d1_b}, {ref_mem[40], ref_mem[41]});
    else passed++;
    read_b = 1'b0;
    #1;
    total++;
    if (d0_b !== 8'h00) $display("FAIL disabled_b_lat0 got %h required 00", d0_b);
    else passed++;
    tick;
    total++;
    if ({d1_a, d1_b} !== {ref_mem[40], 8'h00})
      $display("FAIL disabled_b_lat1 got %h required %h", {d1_a, d1_b}, {ref_mem[40], 8'h00});
    else passed++;
  endtask

  task automatic test_bypass;
    read_a = 1'b0; read_b = 1'b0;
    write_mem = 1'b1; wr_addr = 8'd7; data_in = 8'd9; tick;
    ref_mem[7] = 8'd9;
    data_in = 8'd200; read_a = 1'b1; rd_addr_a = 8'd7;
    #1;
    total++;
    if (d0_a !== 8'd9) $display("FAIL bypass_lat0_before got %0d required 9", d0_a);
    else passed++;
    tick;
    write_mem = 1'b0;
    ref_mem[7] = 8'd200;
    total++;
    if (d1_a !== 8'd200) $display("FAIL bypass_lat1 got %0d required 200", d1_a);
    else passed++;
    total++;
    if (d0_a !== 8'd200) $display("FAIL bypass_lat0_after got %0d required 200", d0_a);
    else passed++;
  endtask

  task automatic test_random;
    logic [7:0] exp_a, exp_b;
    for (int n = 0; n < 200; n++) begin
      write_mem = 1'($urandom_range(0, 1));
      wr_addr   = $urandom_range(0, 1) ? 8'(40 + $urandom_range(0, 3)) : 8'($urandom);
      rd_addr_a = $urandom_range(0, 2) != 0 ? 8'(40 + $urandom_range(0, 3)) : 8'($urandom);
      rd_addr_b = $urandom_range(0, 2) != 0 ? 8'(40 + $urandom_range(0, 3)) : 8'($urandom);
      data_in   = 8'($urandom);
      read_a    = 1'($urandom_range(0, 1));
      read_b    = 1'($urandom_range(0, 1));
      #1;
      exp_a = read_a ? ref_mem[rd_addr_a] : 8'h00;
      exp_b = read_b ? ref_mem[rd_addr_b] : 8'h00;
      total++;
      if ({d0_a, d0_b} !== {exp_a, exp_b})
        $display("FAIL rand_lat0 n=%0d got %h required %h", n, {d0_a, d0_b}, {exp_a, exp_b});
      else passed++;
      // Registered view: what the read sees on this edge, including the write in flight.
      if (read_a && write_mem && wr_addr == rd_addr_a) exp_a = data_in;
      if (read_b && write_mem && wr_addr == rd_addr_b) exp_b = data_in;
      tick;
      total++;
      if ({d1_a, d1_b} !== {exp_a, exp_b})
        $display("FAIL rand_lat1 n=%0d got %h required %h", n, {d1_a, d1_b}, {exp_a, exp_b});
      else passed++;
      if (write_mem) ref_mem[wr_addr] = data_in;
    end
    write_mem = 1'b0; read_a = 1'b0; read_b = 1'b0;
  endtask

  task automatic test_small;
    s_write = 1'b1; s_wr_addr = 4'd15; s_data_in = 16'hBEEF; tick;
    s_write = 1'b0;
    s_read_b = 1'b1; s_rd_addr_b = 4'd15;
    s_read_a = 1'b1; s_rd_addr_a = 4'd15;
    #1;
    total++;
    if (s_b !== 16'hBEEF) $display("FAIL small_read_b got %h required BEEF", s_b);
    else passed++;
    total++;
    if (s_a !== 16'hBEEF) $display("FAIL small_same_addr_a got %h required BEEF", s_a);
    else passed++;
    s_read_b = 1'b0;
    #1;
    total++;
    if (s_b !== 16'h0000) $display("FAIL small_disabled_b got %h required 0000", s_b);
    else passed++;
    s_read_a = 1'b0;
  endtask

  task automatic test_mid_reset;
    bit dropped = 1'b0;
    reset = 1'b1; tick;
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (d0_busy !== 1'b1) dropped = 1'b1;
    end
    reset = 1'b1; tick;
    total++;
    if (dropped || d0_busy !== 1'b1)
      $display("FAIL mid_reset_busy got dropped=%0b busy=%b required busy held 1", dropped,
               d0_busy);
    else passed++;
    test_sweep(1'b0);
    read_a = 1'b1; rd_addr_a = 8'd16;
    #1;
    total++;
    if (d0_a !== 8'd254) $display("FAIL mid_reset_preset got %0d required 254", d0_a);
    else passed++;
    read_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    wr_addr = '0; data_in = '0; write_mem = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; read_a = 1'b0; read_b = 1'b0;
    s_wr_addr = '0; s_data_in = '0; s_write = 1'b0;
    s_rd_addr_a = '0; s_rd_addr_b = '0; s_read_a = 1'b0; s_read_b = 1'b0;
    test_reset;
    test_sweep(1'b1);
    test_presets;
    test_dual_read;
    test_bypass;
    test_random;
    test_small;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
